// File: rtl/rr_mux_scheduler.sv
// Round-robin 4:1 mux scheduler with lockable bursts.
// An owner is picked in IDLE by rotating priority from ptr; in OWN the owner
// streams beats into a registered output stage until it unlocks, exhausts
// MAX_BURST, or drops its request.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests starting at ptr
// OWN   | owner = S; capture its beats whenever the output stage can load
module rr_mux_scheduler #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [3:0]        lock,
    input  logic [DATA_W-1:0] J,
    input  logic [DATA_W-1:0] K,
    input  logic [DATA_W-1:0] L,
    input  logic [DATA_W-1:0] M,
    input  logic              out_ready,
    output logic [1:0]        S,
    output logic [3:0]        gnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] Y,
    output logic              busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Five bits so that a count of 15 plus one can still equal MAX_BURST=16.
    localparam logic [4:0] LP_MAX = 5'(MAX_BURST);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_s;
    logic [1:0]        r_ptr;
    logic [4:0]        r_burst;
    logic              r_valid;
    logic [DATA_W-1:0] r_y;

    logic              w_load;
    logic              w_beat;
    logic              w_release;
    logic [3:0]        w_rot;
    logic [1:0]        w_off;
    logic [1:0]        w_pick;
    logic [4:0]        w_burst_inc;
    logic [DATA_W-1:0] w_data;

    assign w_load      = !r_valid || out_ready;
    assign w_burst_inc = r_burst + 5'd1;

    // Rotate requests so that bit 0 corresponds to ptr; first set bit wins.
    assign w_rot  = 4'({req, req} >> r_ptr);
    assign w_pick = r_ptr + w_off;

    // Priority encode the rotated request vector.
    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    // Shared 4:1 data mux driven by the registered owner index.
    always_comb begin
        w_data = J;
        case (r_s)
            2'd0: w_data = J;
            2'd1: w_data = K;
            2'd2: w_data = L;
            2'd3: w_data = M;
            default: w_data = J;
        endcase
    end

    // Next-state, beat/release decision and grant pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_release   = 1'b0;
        gnt         = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (|req) w_state_nxt = ST_OWN;
            end
            ST_OWN: begin
                w_beat     = req[r_s] && w_load;
                gnt[r_s]   = w_beat;
                // A stalled owner that still requests keeps the grant; lock is
                // only sampled on the beat itself.
                if (w_beat) w_release = !lock[r_s] || (w_burst_inc == LP_MAX);
                else        w_release = !req[r_s];
                if (w_release) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Owner index, rotation pointer and burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= 2'd0;
            r_ptr   <= 2'd0;
            r_burst <= 5'd0;
        end else begin
            if (r_state == ST_IDLE && |req) begin
                r_s     <= w_pick;
                r_burst <= 5'd0;
            end else if (w_beat) begin
                r_burst <= w_burst_inc;
            end
            if (w_release) r_ptr <= r_s + 2'd1;
        end
    end

    // Registered output stage: capture on beat, drain on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_y     <= '0;
        end else if (w_beat) begin
            r_valid <= 1'b1;
            r_y     <= w_data;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign S         = r_s;
    assign out_valid = r_valid;
    assign Y         = r_y;
    assign busy      = (r_state == ST_OWN);

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Bench for rr_mux_scheduler: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_rr_mux_scheduler;

    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = 4'd0;
    logic [3:0]    lock = 4'd0;
    logic [DW-1:0] J = '0, K = '0, L = '0, M = '0;
    logic          out_ready = 1'b1;
    logic [1:0]    S;
    logic [3:0]    gnt;
    logic          out_valid;
    logic [DW-1:0] Y;
    logic          busy;

    rr_mux_scheduler #(.DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .J(J), .K(K), .L(L), .M(M), .out_ready(out_ready),
        .S(S), .gnt(gnt), .out_valid(out_valid), .Y(Y), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: who owns the output, where rotation resumes, how many
    // beats the owner has sent, and what sits in the output register.
    bit            m_own;
    int            m_s, m_ptr, m_cnt;
    bit            m_valid;
    logic [DW-1:0] m_y;

    // Values observed at the most recent sample point.
    logic [3:0]    s_gnt;
    logic [1:0]    s_s;
    logic          s_valid;
    logic [DW-1:0] s_y;

    function automatic logic [DW-1:0] data_of(int i);
        case (i)
            0: return J;
            1: return K;
            2: return L;
            default: return M;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_s = 0; m_ptr = 0; m_cnt = 0; m_valid = 0; m_y = '0;
    endtask

    task automatic model_release();
        m_own = 0;
        m_ptr = (m_s + 1) % 4;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit load;
        bit found;
        load = !m_valid || out_ready;
        if (!m_own) begin
            if (req != 4'd0) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && req[(m_ptr + k) % 4]) begin
                        m_s = (m_ptr + k) % 4;
                        found = 1;
                    end
                end
                m_cnt = 0;
                m_own = 1;
            end
            if (m_valid && out_ready) m_valid = 0;
        end else if (req[m_s] && load) begin
            m_y = data_of(m_s);
            m_valid = 1;
            m_cnt++;
            if (!lock[m_s] || m_cnt == MB) model_release();
        end else begin
            if (m_valid && out_ready) m_valid = 0;
            if (!req[m_s]) model_release();
        end
    endtask

    // One cycle: compare at the falling edge, step the model, then move
    // just past the rising edge where the caller may change inputs.
    task automatic tick();
        logic [3:0] exp_gnt;
        @(negedge clk);
        if (!rst_n) model_reset();
        exp_gnt = 4'd0;
        if (m_own && req[m_s] && (!m_valid || out_ready)) exp_gnt[m_s] = 1'b1;
        check("S", S, m_s);
        check("gnt", gnt, exp_gnt);
        check("out_valid", out_valid, m_valid);
        check("Y", Y, m_y);
        check("busy", busy, m_own);
        s_gnt = gnt; s_s = S; s_valid = out_valid; s_y = Y;
        if (rst_n) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check("rst_valid", s_valid, 1'b0);
        check("rst_S", s_s, 2'd0);
        check("rst_Y", s_y, 8'h00);
        rst_n = 1'b1;
    endtask

    int ga29[10] = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1};
    int ya29[10] = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    int ga30[7]  = '{0, 2, 2, 2, 2, 0, 4};

    initial begin
        model_reset();
        J = 8'h11; K = 8'h22; L = 8'h33; M = 8'h44;
        tick();
        do_reset();

        // Full request, no lock: strict rotation with an IDLE cycle between.
        req = 4'b1111; lock = 4'b0000; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rot_gnt", s_gnt, ga29[i]);
            check("rot_Y", s_y, ya29[i]);
        end

        // Locked K bursts MAX_BURST beats, then L wins from ptr=2.
        do_reset();
        req = 4'b0110; lock = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("burst_gnt", s_gnt, ga30[i]);
        end

        // Stall: owner J keeps requesting while downstream is blocked.
        do_reset();
        req = 4'b0001; lock = 4'b0001;
        tick();
        tick();
        check("stall_first", s_gnt, 4'b0001);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_gnt", s_gnt, 4'b0000);
            check("stall_Y", s_y, 8'h11);
            check("stall_S", s_s, 2'd0);
        end
        out_ready = 1'b1;
        tick();
        check("stall_resume", s_gnt, 4'b0001);

        // Reset during a locked burst of M, then K is first from ptr=0.
        do_reset();
        req = 4'b1000; lock = 4'b1000;
        tick();
        tick();
        tick();
        check("m_burst", s_gnt, 4'b1000);
        do_reset();
        req = 4'b1010; lock = 4'b0000;
        tick();
        tick();
        check("post_rst_gnt", s_gnt, 4'b0010);

        // Randomized traffic with idle windows and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
            req       = ((c % 200) < 12) ? 4'd0 : 4'($urandom);
            lock      = 4'($urandom) | 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            J = 8'($urandom); K = 8'($urandom); L = 8'($urandom); M = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_scheduler.md
RR_MUX_SCHEDULER -- requirements
Module: rr_mux_scheduler

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, width of each data input and of Y; MAX_BURST, default 4, maximum beats per grant (legal range 1..16).
REQ-002 Ports SHALL be, clock and reset first: clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset; reset is asynchronous and active-low.
REQ-004 req  in  4  req[i] = requester i has a beat pending (i: 0=J, 1=K, 2=L, 3=M).
REQ-005 lock  in  4  lock[i] = requester i asks to keep the grant after its current beat.
REQ-006 J, K, L, M  in  DATA_W each  requester data words.
REQ-007 out_ready  in  1  downstream accepts Y this cycle.
REQ-008 S  out  2  registered owner index; drives the select of the shared 4:1 mux.
REQ-009 gnt  out  4  one-hot pulse; gnt[i]=1 in the cycle requester i's beat is captured.
REQ-010 out_valid  out  1  Y holds an unconsumed beat.
REQ-011 Y  out  DATA_W  registered output data.
REQ-012 busy  out  1  high while state is OWN.

Function
REQ-013 FSM SHALL have two states: IDLE (no owner) and OWN (owner = S).
REQ-014 load SHALL be defined as (!out_valid || out_ready).
REQ-015 IDLE: if any req bit is set, next owner SHALL be the first set req bit scanning ptr, ptr+1, ... mod 4; S <= owner, burst count <= 0, go to OWN; otherwise stay in IDLE and hold S.
REQ-016 OWN: beat = req[S] && load; gnt[S] SHALL equal beat, combinationally; all other gnt bits SHALL be 0; gnt SHALL be all-zero in IDLE.
REQ-017 On beat, Y SHALL be loaded with the data of S (00=J, 01=K, 10=L, 11=M), out_valid <= 1, and burst count incremented.
REQ-018 Release SHALL occur on a beat when !lock[S] or burst count+1 == MAX_BURST; release also SHALL occur in OWN when !req[S], with no beat.
REQ-019 On release, ptr <= S+1 mod 4 and state <= IDLE; S SHALL hold its value.
REQ-020 When out_valid && out_ready and there is no beat, out_valid SHALL clear next cycle.
REQ-021 Stall (out_valid && !out_ready): no beat occurs; Y, out_valid, S, and burst count SHALL hold; a lock change during the stall SHALL take effect only at the next beat.
REQ-022 Latency: req rising in IDLE at cycle n gives S valid at n+1, gnt at n+1 if load, and out_valid at n+2.
REQ-023 Throughput: a locked owner with out_ready=1 SHALL transfer one beat per cycle; each new grant costs one IDLE cycle.
REQ-024 Requests arriving while in OWN SHALL NOT preempt the owner.
REQ-025 ptr SHALL change only on release.
REQ-026 With MAX_BURST=1, every beat SHALL release regardless of lock.

Reset
REQ-027 While rst_n=0, outputs SHALL be asynchronously forced to: state IDLE, S=00, ptr=0, burst count=0, out_valid=0, Y=0, busy=0, gnt=0.
REQ-028 Reset mid-burst SHALL discard the owner and any pending Y beat; the first arbitration after release SHALL start from requester 0.

Verification
REQ-029 All req=1111, lock=0, out_ready=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 with one IDLE cycle between beats; Y sequence J, K, L, M, J.
REQ-030 MAX_BURST=4, req[1]=1 and lock[1]=1 held, req[2]=1 -> four consecutive K beats, then release, then L granted (ptr=2).
REQ-031 out_ready=0 for 3 cycles with out_valid=1 and owner requesting -> Y and S stable, gnt=0000; on out_ready=1 the next beat is captured in that same cycle.
REQ-032 Owner drops req in OWN with no beat -> release, ptr=owner+1, gnt never pulses for that owner.
REQ-033 rst_n low during a locked burst of requester 3 -> next cycle out_valid=0, S=00, Y=0; after release with req=1010, requester 1 is granted first.
REQ-034 req=0000 for 10 cycles -> state stays IDLE, S unchanged, out_valid falls after first accept, gnt=0000.
